// File: rtl/vel_ramp_sequencer.sv
// vel_ramp_sequencer: run/stop sequencer for the PI velocity loop.
// Turns a commanded target velocity into an acceleration-limited desired_vel
// setpoint, gates the loop with ctrl_en, issues a periodic sample_tick and
// latches emergency-stop faults.
// Optional feature macro: STALL_DETECT_EN (stall-fault detection while holding).
module vel_ramp_sequencer #(
  parameter int SAMPLE_DIV    = 100000,
  parameter int VEL_W         = 32,
  parameter int STALL_SAMPLES = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    estop,
  input  logic                    fault_clear,
  input  logic signed [VEL_W-1:0] target_vel,
  input  logic [15:0]             accel_step,
  input  logic signed [VEL_W-1:0] actual_vel,
  output logic signed [VEL_W-1:0] desired_vel,
  output logic                    ctrl_en,
  output logic                    sample_tick,
  output logic [2:0]              state,
  output logic                    fault,
  output logic [1:0]              fault_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int              CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0]        cnt_r, cnt_next_s;
  logic                    sample_tick_r, tick_s;
  state_t                  state_r, state_next_s;
  logic signed [VEL_W-1:0] desired_r, desired_next_s;
  logic signed [VEL_W-1:0] ramp_s, stop_ramp_s;
  logic                    ctrl_en_r, fault_r;
  logic [1:0]              fault_code_r, code_next_s;
  logic                    stall_hit_s;

  // One rate-limited step from cur toward tgt. The difference is formed one
  // bit wider so opposite-sign extremes cannot wrap; a zero step means 1.
  function automatic logic signed [VEL_W-1:0] ramp_toward(
    input logic signed [VEL_W-1:0] cur,
    input logic signed [VEL_W-1:0] tgt,
    input logic [15:0]             acc
  );
    logic signed [VEL_W:0] diff_s;
    logic signed [VEL_W:0] step_s;
    diff_s = {tgt[VEL_W-1], tgt} - {cur[VEL_W-1], cur};
    step_s = (acc == 16'd0) ? (VEL_W+1)'(1) : (VEL_W+1)'(acc);
    if (diff_s > step_s) begin
      ramp_toward = cur + step_s[VEL_W-1:0];
    end else if (diff_s < -step_s) begin
      ramp_toward = cur - step_s[VEL_W-1:0];
    end else begin
      ramp_toward = tgt;
    end
  endfunction

  assign tick_s      = (cnt_r == CNT_LAST);
  assign ramp_s      = ramp_toward(desired_r, target_vel, accel_step);
  assign stop_ramp_s = ramp_toward(desired_r, {VEL_W{1'b0}}, accel_step);

  // Free-running sample counter next value, wrapping at SAMPLE_DIV-1
  always_comb begin
    cnt_next_s = cnt_r + CNT_W'(1);
    if (cnt_r == CNT_LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Sample counter and registered tick strobe (high while count is SAMPLE_DIV-1)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r         <= '0;
      sample_tick_r <= 1'b0;
    end else begin
      cnt_r         <= cnt_next_s;
      sample_tick_r <= (cnt_next_s == CNT_LAST);
    end
  end

`ifdef STALL_DETECT_EN
  localparam int               STALL_W    = $clog2(STALL_SAMPLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_SAMPLES);

  logic [STALL_W-1:0] stall_cnt_r, stall_cnt_next_s;

  // Count consecutive ticks held at a nonzero setpoint with no measured motion
  always_comb begin
    stall_cnt_next_s = stall_cnt_r;
    stall_hit_s      = 1'b0;
    if (state_r != ST_HOLD) begin
      stall_cnt_next_s = '0;
    end else if (tick_s && (actual_vel != {VEL_W{1'b0}})) begin
      stall_cnt_next_s = '0;
    end else if (tick_s && (desired_r != {VEL_W{1'b0}})) begin
      stall_cnt_next_s = stall_cnt_r + STALL_W'(1);
      stall_hit_s      = (stall_cnt_next_s == STALL_LAST);
    end else begin
      stall_cnt_next_s = stall_cnt_r;
    end
  end

  // Stall counter register, cleared whenever HOLD is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (state_next_s != ST_HOLD) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_next_s;
    end
  end
`else
  logic stall_unused_s;
  assign stall_hit_s    = 1'b0;
  assign stall_unused_s = ^{actual_vel, 32'(STALL_SAMPLES)};
`endif

  // Next-state, setpoint and fault-code logic; estop outranks stop, stop outranks start
  always_comb begin
    state_next_s   = state_r;
    desired_next_s = desired_r;
    code_next_s    = fault_code_r;
    if (estop) begin
      state_next_s   = ST_FAULT;
      desired_next_s = '0;
      if (state_r != ST_FAULT) begin
        code_next_s = 2'd1;
      end else begin
        code_next_s = fault_code_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          desired_next_s = '0;
          if (start) begin
            state_next_s = ST_RAMP;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (stop) begin
            state_next_s = ST_STOP;
          end else if (tick_s) begin
            desired_next_s = ramp_s;
            if (ramp_s == target_vel) begin
              state_next_s = ST_HOLD;
            end else begin
              state_next_s = ST_RAMP;
            end
          end else begin
            state_next_s = ST_RAMP;
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state_next_s = ST_STOP;
          end else if (tick_s && (target_vel != desired_r)) begin
            // Re-enter RAMP now; the first step lands on the following tick.
            state_next_s = ST_RAMP;
          end else if (stall_hit_s) begin
            state_next_s   = ST_FAULT;
            desired_next_s = '0;
            code_next_s    = 2'd2;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            desired_next_s = stop_ramp_s;
            if (stop_ramp_s == {VEL_W{1'b0}}) begin
              state_next_s = ST_IDLE;
            end else begin
              state_next_s = ST_STOP;
            end
          end else begin
            state_next_s = ST_STOP;
          end
        end
        ST_FAULT: begin
          desired_next_s = '0;
          if (fault_clear) begin
            state_next_s = ST_IDLE;
            code_next_s  = 2'd0;
          end else begin
            state_next_s = ST_FAULT;
          end
        end
        default: begin
          state_next_s   = ST_IDLE;
          desired_next_s = '0;
          code_next_s    = 2'd0;
        end
      endcase
    end
  end

  // Registered state and outputs; ctrl_en/fault follow the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      desired_r    <= '0;
      ctrl_en_r    <= 1'b0;
      fault_r      <= 1'b0;
      fault_code_r <= 2'd0;
    end else begin
      state_r      <= state_next_s;
      desired_r    <= desired_next_s;
      ctrl_en_r    <= (state_next_s == ST_RAMP) || (state_next_s == ST_HOLD) ||
                      (state_next_s == ST_STOP);
      fault_r      <= (state_next_s == ST_FAULT);
      fault_code_r <= code_next_s;
    end
  end

  assign desired_vel = desired_r;
  assign ctrl_en     = ctrl_en_r;
  assign sample_tick = sample_tick_r;
  assign state       = state_r;
  assign fault       = fault_r;
  assign fault_code  = fault_code_r;

endmodule

// File: tb/tb_vel_ramp_sequencer.sv
// Testbench for vel_ramp_sequencer (SAMPLE_DIV=4): directed scenarios plus a
// randomized ramp/stop run against an arithmetic reference model.
module tb_vel_ramp_sequencer;
  localparam int DIV = 4;

  logic               clk = 1'b0;
  logic               reset, start, stop, estop, fault_clear;
  logic signed [31:0] target_vel, actual_vel, desired_vel;
  logic [15:0]        accel_step;
  logic               ctrl_en, sample_tick, fault;
  logic [2:0]         state;
  logic [1:0]         fault_code;

  int checks = 0;
  int errors = 0;

  vel_ramp_sequencer #(.SAMPLE_DIV(DIV), .VEL_W(32), .STALL_SAMPLES(200)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .estop(estop),
    .fault_clear(fault_clear), .target_vel(target_vel), .accel_step(accel_step),
    .actual_vel(actual_vel), .desired_vel(desired_vel), .ctrl_en(ctrl_en),
    .sample_tick(sample_tick), .state(state), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Reference step: move cur toward tgt by at most max(acc,1), never past tgt.
  function automatic longint model_step(input longint cur, input longint tgt, input int acc);
    longint lim = (acc == 0) ? 1 : acc;
    longint d   = tgt - cur;
    if (d > lim) return cur + lim;
    if (d < -lim) return cur - lim;
    return tgt;
  endfunction

  function automatic longint rand_target(input int eff);
    longint m = longint'(eff) * $urandom_range(0, 8) + $urandom_range(0, eff);
    return ($urandom_range(0, 1) == 1) ? m : -m;
  endfunction

  // Advance to the negedge just after the next sample tick has been processed.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (sample_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tick_timeout: sample_tick stayed 0, required 1 within %0d cycles", 2 * DIV);
    end
    @(negedge clk);
  endtask

  task automatic go_idle();
    estop = 1'b1;
    @(negedge clk);
    estop = 1'b0;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    checks++;
    if (state !== 3'd0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL go_idle: state=%0d code=%0d required state=0 code=0", state, fault_code);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; estop = 1'b0; fault_clear = 1'b0;
    target_vel = 32'sd0; accel_step = 16'd0; actual_vel = 32'sd0;
    repeat (3) @(negedge clk);
    checks++;
    if (desired_vel !== 32'sd0 || ctrl_en !== 1'b0 || sample_tick !== 1'b0 ||
        state !== 3'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: desired=%0d en=%b tick=%b state=%0d fault=%b code=%0d required all 0",
               desired_vel, ctrl_en, sample_tick, state, fault, fault_code);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (sample_tick !== ((k % DIV) == 3)) begin
        errors++;
        $display("FAIL tick_period: cycle %0d tick=%b required %b", k, sample_tick, (k % DIV) == 3);
      end
    end
  endtask

  task automatic test_ramp_up();
    int exp_v[4] = '{300, 600, 900, 1000};
    target_vel = 32'sd1000; accel_step = 16'd300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || ctrl_en !== 1'b1 || desired_vel !== 32'sd0) begin
      errors++;
      $display("FAIL start_to_ramp: state=%0d en=%b desired=%0d required 1 1 0", state, ctrl_en, desired_vel);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      checks++;
      if (desired_vel !== 32'(exp_v[i]) || state !== ((i == 3) ? 3'd2 : 3'd1)) begin
        errors++;
        $display("FAIL ramp_up: tick %0d desired=%0d state=%0d required %0d %0d",
                 i + 1, desired_vel, state, exp_v[i], (i == 3) ? 2 : 1);
      end
    end
  endtask

  task automatic test_ramp_down();
    int exp_v[4] = '{700, 400, 100, 0};
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (state !== 3'd3 || ctrl_en !== 1'b1 || desired_vel !== 32'sd1000) begin
      errors++;
      $display("FAIL stop_entry: state=%0d en=%b desired=%0d required 3 1 1000", state, ctrl_en, desired_vel);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      checks++;
      if (desired_vel !== 32'(exp_v[i]) || state !== ((i == 3) ? 3'd0 : 3'd3) ||
          ctrl_en !== (i != 3)) begin
        errors++;
        $display("FAIL ramp_down: tick %0d desired=%0d state=%0d en=%b required %0d %0d %b",
                 i + 1, desired_vel, state, ctrl_en, exp_v[i], (i == 3) ? 0 : 3, i != 3);
      end
    end
  endtask

  task automatic test_negative_and_retarget();
    int exp_r[3] = '{-5, -1, 3};
    target_vel = -32'sd5; accel_step = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wait_tick();
      checks++;
      if (desired_vel !== 32'(-i) || state !== ((i == 5) ? 3'd2 : 3'd1)) begin
        errors++;
        $display("FAIL negative_ramp: tick %0d desired=%0d state=%0d required %0d %0d",
                 i, desired_vel, state, -i, (i == 5) ? 2 : 1);
      end
    end
    target_vel = 32'sd3; accel_step = 16'd4;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      checks++;
      if (desired_vel !== 32'(exp_r[i]) || state !== ((i == 2) ? 3'd2 : 3'd1)) begin
        errors++;
        $display("FAIL hold_retarget: tick %0d desired=%0d state=%0d required %0d %0d",
                 i + 1, desired_vel, state, exp_r[i], (i == 2) ? 2 : 1);
      end
    end
    go_idle();
  endtask

  task automatic test_ignored_inputs();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    checks++;
    if (state !== 3'd0 || ctrl_en !== 1'b0 || desired_vel !== 32'sd0) begin
      errors++;
      $display("FAIL idle_ignores: state=%0d en=%b desired=%0d required 0 0 0", state, ctrl_en, desired_vel);
    end
    target_vel = 32'sd1000; accel_step = 16'd300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || desired_vel !== 32'sd300) begin
      errors++;
      $display("FAIL restart_ignored: state=%0d desired=%0d required 1 300", state, desired_vel);
    end
    wait_tick();
    checks++;
    if (desired_vel !== 32'sd600) begin
      errors++;
      $display("FAIL ramp_continues: desired=%0d required 600", desired_vel);
    end
    go_idle();
  endtask

  task automatic test_estop();
    target_vel = 32'sd1000; accel_step = 16'd300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tick();
    estop = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || fault !== 1'b1 || desired_vel !== 32'sd0 || ctrl_en !== 1'b0 ||
        fault_code !== 2'd1) begin
      errors++;
      $display("FAIL estop_entry: state=%0d fault=%b desired=%0d en=%b code=%0d required 4 1 0 0 1",
               state, fault, desired_vel, ctrl_en, fault_code);
    end
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    wait_tick();
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd1 || desired_vel !== 32'sd0) begin
      errors++;
      $display("FAIL clear_during_estop: state=%0d code=%0d desired=%0d required 4 1 0",
               state, fault_code, desired_vel);
    end
    estop = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_latched: state=%0d fault=%b required 4 1", state, fault);
    end
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || fault_code !== 2'd0 || ctrl_en !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit: state=%0d fault=%b code=%0d en=%b required 0 0 0 0",
               state, fault, fault_code, ctrl_en);
    end
  endtask

  task automatic test_priority();
    start = 1'b1; stop = 1'b1; estop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; estop = 1'b0;
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd1 || ctrl_en !== 1'b0) begin
      errors++;
      $display("FAIL priority: state=%0d code=%0d en=%b required 4 1 0", state, fault_code, ctrl_en);
    end
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
  endtask

  task automatic test_midrun_reset();
    target_vel = 32'sd1000; accel_step = 16'd300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tick();
    reset = 1'b1;
    #1;
    checks++;
    if (desired_vel !== 32'sd0 || state !== 3'd0 || ctrl_en !== 1'b0 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: desired=%0d state=%0d en=%b tick=%b required all 0",
               desired_vel, state, ctrl_en, sample_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (sample_tick !== ((k % DIV) == 3)) begin
        errors++;
        $display("FAIL tick_restart: cycle %0d tick=%b required %b", k, sample_tick, (k % DIV) == 3);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int     acc, eff;
      longint tgt, exp_d;
      bit     holding;
      acc = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 600));
      eff = (acc == 0) ? 1 : acc;
      tgt = rand_target(eff);
      target_vel = tgt[31:0]; accel_step = 16'(acc);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_d = 0;
      holding = 1'b0;
      for (int t = 0; t < 60; t++) begin
        if (t < 6 && $urandom_range(0, 4) == 0) begin
          tgt = rand_target(eff);
          target_vel = tgt[31:0];
        end
        wait_tick();
        if (holding) begin
          if (tgt != exp_d) holding = 1'b0;
        end else begin
          exp_d = model_step(exp_d, tgt, acc);
          if (exp_d == tgt) holding = 1'b1;
        end
        checks++;
        if (desired_vel !== exp_d[31:0] || state !== (holding ? 3'd2 : 3'd1) || ctrl_en !== 1'b1) begin
          errors++;
          $display("FAIL random_ramp: run %0d tick %0d desired=%0d state=%0d en=%b required %0d %0d 1",
                   it, t, desired_vel, state, ctrl_en, exp_d, holding ? 2 : 1);
        end
        if (holding && t >= 6) break;
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      for (int t = 0; t < 40; t++) begin
        wait_tick();
        exp_d = model_step(exp_d, 0, acc);
        checks++;
        if (desired_vel !== exp_d[31:0] || state !== ((exp_d == 0) ? 3'd0 : 3'd3)) begin
          errors++;
          $display("FAIL random_stop: run %0d tick %0d desired=%0d state=%0d required %0d %0d",
                   it, t, desired_vel, state, exp_d, (exp_d == 0) ? 0 : 3);
        end
        if (exp_d == 0) break;
      end
      go_idle();
    end
  endtask

`ifdef STALL_DETECT_EN
  task automatic test_stall();
    actual_vel = 32'sd0; target_vel = 32'sd500; accel_step = 16'd500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tick();
    repeat (199) wait_tick();
    checks++;
    if (state !== 3'd2 || desired_vel !== 32'sd500) begin
      errors++;
      $display("FAIL stall_early: state=%0d desired=%0d required 2 500", state, desired_vel);
    end
    wait_tick();
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd2 || desired_vel !== 32'sd0 || ctrl_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_fault: state=%0d code=%0d desired=%0d en=%b required 4 2 0 0",
               state, fault_code, desired_vel, ctrl_en);
    end
    go_idle();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_negative_and_retarget();
    test_ignored_inputs();
    test_estop();
    test_priority();
    test_random();
`ifdef STALL_DETECT_EN
    test_stall();
`endif
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
